// File: rtl/alu_share_arbiter.sv
// Shares one single-cycle ALU between NUM_REQ requesters: round-robin grant, registered operands and response.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
package alu_share_pkg;
    typedef enum logic [3:0] {
        i_ADD  = 4'd0,
        i_SUB  = 4'd1,
        i_AND  = 4'd2,
        i_OR   = 4'd3,
        i_XOR  = 4'd4,
        i_SLL  = 4'd5,
        i_SRL  = 4'd6,
        i_SRA  = 4'd7,
        i_SLT  = 4'd8,
        i_SLTU = 4'd9
    } alu_op_t;
endpackage

module alu_share_arbiter
    import alu_share_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  alu_op_t [NUM_REQ-1:0]       req_op,
    input  logic [NUM_REQ-1:0]          req_is_imm,
    input  logic [NUM_REQ-1:0][31:0]    req_rs1,
    input  logic [NUM_REQ-1:0][31:0]    req_rs2,
    input  logic [NUM_REQ-1:0][31:0]    req_imm,
    output logic [NUM_REQ-1:0]          rsp_valid,
    input  logic [NUM_REQ-1:0]          rsp_ready,
    output logic [31:0]                 rsp_data,
    output alu_op_t                     alu_op,
    output logic                        alu_is_imm,
    output logic [31:0]                 alu_rs1,
    output logic [31:0]                 alu_rs2,
    output logic [31:0]                 alu_imm,
    input  logic [31:0]                 alu_rd_data
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t               state_reg;
    logic [IDX_W-1:0]     rr_ptr_reg;
    logic [IDX_W-1:0]     grant_reg;
    logic [NUM_REQ-1:0]   rsp_valid_reg;
    logic [31:0]          rsp_data_reg;
    alu_op_t              alu_op_reg;
    logic                 alu_is_imm_reg;
    logic [31:0]          alu_rs1_reg;
    logic [31:0]          alu_rs2_reg;
    logic [31:0]          alu_imm_reg;

    logic                 grant_found;
    logic [IDX_W-1:0]     grant_idx;
    logic [IDX_W:0]       scan_idx;
    logic [NUM_REQ-1:0]   grant_dec;

    // Scan upward from rr_ptr with wrap; first valid requester wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = {1'b0, rr_ptr_reg} + (IDX_W+1)'(k);
            if (scan_idx >= (IDX_W+1)'(NUM_REQ))
                scan_idx = scan_idx - (IDX_W+1)'(NUM_REQ);
            if (!grant_found && req_valid[scan_idx[IDX_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx[IDX_W-1:0];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_sel
            assign req_ready[gi] = (state_reg == IDLE) && !reset && grant_found
                                   && (grant_idx == IDX_W'(gi));
            assign grant_dec[gi] = (grant_reg == IDX_W'(gi));
        end
    endgenerate

`ifndef ALU_ARB_FIXED_PRIO_EN
    logic [IDX_W-1:0] rr_ptr_next;
    assign rr_ptr_next = (grant_idx == IDX_W'(NUM_REQ-1)) ? '0 : grant_idx + IDX_W'(1);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            rr_ptr_reg     <= '0;
            grant_reg      <= '0;
            rsp_valid_reg  <= '0;
            rsp_data_reg   <= '0;
            alu_op_reg     <= i_ADD;
            alu_is_imm_reg <= 1'b0;
            alu_rs1_reg    <= '0;
            alu_rs2_reg    <= '0;
            alu_imm_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_found) begin
                        alu_op_reg     <= req_op[grant_idx];
                        alu_is_imm_reg <= req_is_imm[grant_idx];
                        alu_rs1_reg    <= req_rs1[grant_idx];
                        alu_rs2_reg    <= req_rs2[grant_idx];
                        alu_imm_reg    <= req_imm[grant_idx];
                        grant_reg      <= grant_idx;
`ifndef ALU_ARB_FIXED_PRIO_EN
                        rr_ptr_reg     <= rr_ptr_next;
`endif
                        state_reg      <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data_reg  <= alu_rd_data;
                    rsp_valid_reg <= grant_dec;
                    state_reg     <= RESP;
                end
                RESP: begin
                    if (rsp_ready[grant_reg]) begin
                        rsp_valid_reg <= '0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign rsp_valid  = rsp_valid_reg;
    assign rsp_data   = rsp_data_reg;
    assign alu_op     = alu_op_reg;
    assign alu_is_imm = alu_is_imm_reg;
    assign alu_rs1    = alu_rs1_reg;
    assign alu_rs2    = alu_rs2_reg;
    assign alu_imm    = alu_imm_reg;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a small behavioural ALU closing the loop.
module tb_alu_share_arbiter;
    import alu_share_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    alu_op_t [1:0]     req_op;
    logic [1:0]        req_is_imm;
    logic [1:0][31:0]  req_rs1;
    logic [1:0][31:0]  req_rs2;
    logic [1:0][31:0]  req_imm;
    logic [1:0]        rsp_valid;
    logic [1:0]        rsp_ready;
    logic [31:0]       rsp_data;
    alu_op_t           alu_op;
    logic              alu_is_imm;
    logic [31:0]       alu_rs1;
    logic [31:0]       alu_rs2;
    logic [31:0]       alu_imm;
    logic [31:0]       alu_rd_data;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.NUM_REQ(2)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_is_imm(req_is_imm), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .alu_op(alu_op), .alu_is_imm(alu_is_imm), .alu_rs1(alu_rs1),
        .alu_rs2(alu_rs2), .alu_imm(alu_imm), .alu_rd_data(alu_rd_data)
    );

    // Reference ALU; unknown opcodes return a marker the arbiter must forward untouched.
    always_comb begin
        alu_rd_data = 32'hDEAD_BEEF;
        case (alu_op)
            i_ADD: alu_rd_data = alu_rs1 + (alu_is_imm ? alu_imm : alu_rs2);
            i_SUB: alu_rd_data = alu_rs1 - alu_rs2;
            i_AND: alu_rd_data = alu_rs1 & alu_rs2;
            i_OR:  alu_rd_data = alu_rs1 | alu_rs2;
            i_XOR: alu_rd_data = alu_rs1 ^ alu_rs2;
            default: alu_rd_data = 32'hDEAD_BEEF;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        $display("check %-16s obs=0x%08h exp=0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input int r, input alu_op_t op, input logic imm_sel,
                           input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm);
        req_op[r] = op; req_is_imm[r] = imm_sel;
        req_rs1[r] = rs1; req_rs2[r] = rs2; req_imm[r] = imm;
    endtask

    // One full transaction from IDLE: accept, exec, response with immediate handshake.
    task automatic serve(input string tag, input int g, input logic [31:0] exp);
        logic [1:0] onehot;
        onehot = 2'b01 << g;
        #1;
        check({tag, ".ready"}, 32'(req_ready), 32'(onehot));
        tick();
        check({tag, ".ready_x"}, 32'(req_ready), 32'h0);
        check({tag, ".vld_x"}, 32'(rsp_valid), 32'h0);
        tick();
        check({tag, ".rsp_vld"}, 32'(rsp_valid), 32'(onehot));
        check({tag, ".rsp_data"}, rsp_data, exp);
        rsp_ready = 2'b11;
        tick();
        rsp_ready = 2'b00;
        check({tag, ".vld_drop"}, 32'(rsp_valid), 32'h0);
    endtask

    initial begin
        reset = 1'b1; req_valid = '0; rsp_ready = '0;
        set_req(0, i_ADD, 1'b0, 0, 0, 0);
        set_req(1, i_ADD, 1'b0, 0, 0, 0);
        tick(); tick(); tick();
        check("rst.rsp_vld", 32'(rsp_valid), 32'h0);
        check("rst.rsp_data", rsp_data, 32'h0);
        check("rst.alu_op", 32'(alu_op), 32'(i_ADD));
        check("rst.alu_rs1", alu_rs1, 32'h0);
        req_valid = 2'b01;
        #1;
        check("rst.ready_gate", 32'(req_ready), 32'h0);
        req_valid = 2'b00;
        reset = 1'b0;
        tick();

        // Single request on requester 0
        set_req(0, i_ADD, 1'b0, 32'd5, 32'd7, 32'd0);
        req_valid = 2'b01;
        serve("single", 0, 32'd12);
        req_valid = 2'b00;
        tick(); tick();
        check("idle.alu_rs1", alu_rs1, 32'd5);
        check("idle.alu_rs2", alu_rs2, 32'd7);

        // Immediate operand on requester 1
        set_req(1, i_ADD, 1'b1, 32'h10, 32'h55, 32'hFFFF_FFFF);
        req_valid = 2'b10;
        serve("imm", 1, 32'h0000_000F);
        req_valid = 2'b00;
        tick();

        // Contention with both requesters held valid
        set_req(0, i_ADD, 1'b0, 32'd1, 32'd2, 32'd0);
        set_req(1, i_SUB, 1'b0, 32'd10, 32'd4, 32'd0);
        req_valid = 2'b11;
`ifdef ALU_ARB_FIXED_PRIO_EN
        serve("cont0", 0, 32'd3);
        serve("cont1", 0, 32'd3);
        serve("cont2", 0, 32'd3);
        req_valid = 2'b10;
        serve("cont3", 1, 32'd6);
`else
        serve("cont0", 0, 32'd3);
        serve("cont1", 1, 32'd6);
        serve("cont2", 0, 32'd3);
        serve("cont3", 1, 32'd6);
`endif
        req_valid = 2'b00;
        tick();

        // Backpressure: stall 5 cycles, non-granted rsp_ready must be ignored
        set_req(0, i_XOR, 1'b0, 32'h0000_F0F0, 32'h0000_FF00, 32'd0);
        set_req(1, i_AND, 1'b0, 32'h0000_00FF, 32'h0000_000F, 32'd0);
        req_valid = 2'b01;
        #1;
        check("bp.ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = 2'b10;
        tick();
        rsp_ready = 2'b10;
        for (int c = 0; c < 5; c++) begin
            check("bp.rsp_vld", 32'(rsp_valid), 32'h1);
            check("bp.rsp_data", rsp_data, 32'h0000_0FF0);
            check("bp.ready", 32'(req_ready), 32'h0);
            tick();
        end
        rsp_ready = 2'b01;
        tick();
        rsp_ready = 2'b00;
        check("bp.vld_drop", 32'(rsp_valid), 32'h0);
        serve("bp.next", 1, 32'h0000_000F);
        req_valid = 2'b00;
        tick();

        // Reset while an op is in EXEC
        set_req(0, i_OR, 1'b0, 32'h0000_00A0, 32'h0000_000B, 32'd0);
        set_req(1, i_ADD, 1'b0, 32'd3, 32'd4, 32'd0);
        req_valid = 2'b01;
        tick();
        req_valid = 2'b11;
        reset = 1'b1;
        tick();
        check("rexec.rsp_vld", 32'(rsp_valid), 32'h0);
        check("rexec.ready", 32'(req_ready), 32'h0);
        check("rexec.alu_rs1", alu_rs1, 32'h0);
        tick();
        check("rexec.no_rsp", 32'(rsp_valid), 32'h0);
        reset = 1'b0;
        serve("rexec.again", 0, 32'h0000_00AB);
        req_valid = 2'b10;
        serve("rexec.r1", 1, 32'd7);
        req_valid = 2'b00;
        tick();

        // Undefined opcode: ALU result forwarded unchanged
        set_req(0, alu_op_t'(4'hF), 1'b0, 32'd1, 32'd1, 32'd0);
        req_valid = 2'b01;
        serve("undef", 0, 32'hDEAD_BEEF);
        req_valid = 2'b00;
        tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
